stream_upsize: RTL
==================

STREAM_UPSIZE -- requirements
Module: stream_upsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 1, bit width of one narrow word.
REQ-002 SHALL have parameter T_DATA_RATIO, default 2, number of narrow words per wide beat; legal values >= 2.
REQ-003 SHALL have parameter T_WIDTH_RATIO, default $clog2(T_DATA_RATIO), word-index counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port s_data_i  input  T_DATA_WIDTH  narrow input word.
REQ-007 SHALL have port s_last_i  input  1  marks final word of a packet.
REQ-008 SHALL have port s_valid_i  input  1  input word valid.
REQ-009 SHALL have port s_ready_o  output  1  input word accepted when high with s_valid_i.
REQ-010 SHALL have port m_data_o  output  unpacked array [T_DATA_RATIO-1:0] of T_DATA_WIDTH  wide beat; element k holds word k.
REQ-011 SHALL have port m_keep_o  output  T_DATA_RATIO  bit k high when m_data_o[k] holds a real word.
REQ-012 SHALL have port m_last_o  output  1  beat closes a packet.
REQ-013 SHALL have port m_valid_o  output  1  wide beat valid.
REQ-014 SHALL have port m_ready_i  input  1  downstream accepts beat.

Function
REQ-015 SHALL transfer an input word only on a clk edge where s_valid_i && s_ready_o; an output beat only where m_valid_o && m_ready_i.
REQ-016 SHALL drive s_ready_o = !m_valid_o || m_ready_i (combinational path m_ready_i -> s_ready_o is intended).
REQ-017 SHALL hold an assembly buffer of T_DATA_RATIO words, a per-word keep mask and an index counter idx (T_WIDTH_RATIO bits, reset 0).
REQ-018 SHALL store an accepted word at position idx of the assembly buffer and set keep bit idx.
REQ-019 SHALL treat an accepted word as completing when idx == T_DATA_RATIO-1 or s_last_i == 1.
REQ-020 On a non-completing accept SHALL increment idx by 1 and leave the output register unchanged.
REQ-021 On a completing accept SHALL, at the same edge, load the output register with the assembly buffer including the new word, keep mask, m_last_o = s_last_i, set m_valid_o = 1, clear the assembly buffer and keep mask to 0, and reset idx to 0.
REQ-022 SHALL present the completed beat on m_valid_o exactly one cycle after the completing accept (latency 1 from final word).
REQ-023 SHALL drive m_data_o[k] = 0 and m_keep_o[k] = 0 for every position k not written in a partial (early s_last_i) beat; m_keep_o SHALL always be contiguous from bit 0.
REQ-024 SHALL hold m_data_o, m_keep_o, m_last_o stable while m_valid_o && !m_ready_i.
REQ-025 On an output handshake with no completing accept in the same cycle SHALL clear m_valid_o to 0 the next cycle.
REQ-026 On an output handshake coinciding with a completing accept SHALL load the new beat and keep m_valid_o = 1 (back-to-back beats, no bubble).
REQ-027 SHALL emit m_last_o = 1 with full keep when s_last_i arrives on word T_DATA_RATIO-1.
REQ-028 SHALL never emit a beat with m_keep_o == 0.
REQ-029 Sustained s_valid_i = 1 and m_ready_i = 1 SHALL yield one input word per cycle with no stall.

Reset
REQ-030 While rst is high SHALL force m_valid_o = 0, m_last_o = 0, m_keep_o = 0, all m_data_o elements = 0, idx = 0, assembly buffer and keep mask = 0, independent of clk.
REQ-031 Assertion of rst mid-packet or mid-stall SHALL discard partial assembly and any pending output beat; first accepted word after release SHALL land at position 0.
REQ-032 s_ready_o SHALL be 1 during and immediately after reset (follows REQ-016 with m_valid_o = 0).

Verification (T_DATA_WIDTH = 8, T_DATA_RATIO = 4)
REQ-033 Words 0x11,0x22,0x33,0x44 (last on 0x44), m_ready_i = 1 -> one beat {0x11,0x22,0x33,0x44}, keep 4'b1111, last 1, valid one cycle after 0x44 accepted.
REQ-034 Words 0xA1,0xA2 with last on 0xA2 -> beat {0xA1,0xA2,0x00,0x00}, keep 4'b0011, last 1; next packet's first word lands at position 0.
REQ-035 Eight continuous words, m_ready_i = 1 -> two beats, last 0 on first, s_ready_o never drops, no bubble between completions.
REQ-036 Beat pending with m_ready_i = 0 for 5 cycles -> s_ready_o = 0, outputs stable all 5 cycles; m_ready_i = 1 -> s_ready_o = 1 same cycle.
REQ-037 rst pulsed after 2 of 4 words accepted -> outputs zero immediately; words 0x55..0x58 after release -> beat {0x55,0x56,0x57,0x58}, keep 4'b1111.
REQ-038 Random s_valid_i / m_ready_i over 1000 words with random last -> scoreboard matches word order, keep and last per beat with zero loss or duplication.

Source files
------------

// File: rtl/stream_upsize.sv
// stream_upsize: packs narrow stream words into one wide beat of T_DATA_RATIO words.
// A beat closes when the last word slot is filled or the input marks end of packet.
// Unfilled slots in a short beat carry zero data and a cleared keep bit.
module stream_upsize #(
    parameter int T_DATA_WIDTH  = 1,
    parameter int T_DATA_RATIO  = 2,
    parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
    output logic [T_DATA_RATIO-1:0] m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    // Assembly state
    logic [T_DATA_WIDTH-1:0]  asm_buf_r   [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0]  asm_keep_r;
    logic [T_WIDTH_RATIO-1:0] idx_r;

    // Output register
    logic [T_DATA_WIDTH-1:0]  out_data_r  [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0]  out_keep_r;
    logic                     out_last_r;
    logic                     out_valid_r;

    // Assembly contents as they would look with the incoming word merged in
    logic [T_DATA_WIDTH-1:0]  buf_next_s  [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0]  keep_next_s;
    logic                     accept_s;
    logic                     complete_s;

    // The output slot is free when empty or being drained this cycle
    assign s_ready_o  = !out_valid_r || m_ready_i;
    assign accept_s   = s_valid_i && s_ready_o;
    assign complete_s = accept_s &&
                        ((idx_r == T_WIDTH_RATIO'(T_DATA_RATIO - 1)) || s_last_i);

    assign m_data_o  = out_data_r;
    assign m_keep_o  = out_keep_r;
    assign m_last_o  = out_last_r;
    assign m_valid_o = out_valid_r;

    // Merge the incoming word into its slot so the completing beat can be loaded in one edge
    always_comb begin
        for (int k = 0; k < T_DATA_RATIO; k++) begin
            buf_next_s[k]  = (idx_r == T_WIDTH_RATIO'(k)) ? s_data_i : asm_buf_r[k];
            keep_next_s[k] = asm_keep_r[k] | (idx_r == T_WIDTH_RATIO'(k));
        end
    end

    // Collect words; a completing word empties the buffer so the next packet starts at slot 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < T_DATA_RATIO; k++) begin
                asm_buf_r[k] <= '0;
            end
            asm_keep_r <= '0;
            idx_r      <= '0;
        end else if (complete_s) begin
            for (int k = 0; k < T_DATA_RATIO; k++) begin
                asm_buf_r[k] <= '0;
            end
            asm_keep_r <= '0;
            idx_r      <= '0;
        end else if (accept_s) begin
            asm_buf_r  <= buf_next_s;
            asm_keep_r <= keep_next_s;
            idx_r      <= idx_r + T_WIDTH_RATIO'(1);
        end else begin
            idx_r      <= idx_r;
        end
    end

    // Load a finished beat (also over a draining one, giving back-to-back beats); hold while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < T_DATA_RATIO; k++) begin
                out_data_r[k] <= '0;
            end
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_data_r  <= buf_next_s;
            out_keep_r  <= keep_next_s;
            out_last_r  <= s_last_i;
            out_valid_r <= 1'b1;
        end else if (m_ready_i) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule
